// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer and the alu_top datapath.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_LOAD   = 2'd1,
    OP_BRANCH = 2'd2,
    OP_NOP    = 2'd3
  } op_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_MEM  = 2'd2;

  // ALU select encodings understood by alu_top
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer driving register-file/ALU controls and a
// load path through a timed memory request/acknowledge handshake.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1_i,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2_i,
  input  logic [ADDR_WIDTH-1:0] cmd_rd_i,
  input  logic [DATA_WIDTH-1:0] cmd_imm_i,
  input  logic                  cmd_use_imm_i,
  input  logic [3:0]            cmd_alu_ctrl_i,
  output logic [ADDR_WIDTH-1:0] rs1_o,
  output logic [ADDR_WIDTH-1:0] rs2_o,
  output logic [ADDR_WIDTH-1:0] rd_o,
  output logic                  reg_write_o,
  output logic                  reg_write_src_o,
  output logic [DATA_WIDTH-1:0] imm_op_o,
  output logic                  alu_src_o,
  output logic [3:0]            alu_ctrl_o,
  input  logic                  eq_i,
  input  logic [DATA_WIDTH-1:0] alu_out_i,
  output logic                  mem_req_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  output logic                  done_o,
  output logic                  branch_taken_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  retired_o
);

  localparam int unsigned TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  state_t                state_q, state_d;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0] imm_q, mem_addr_q;
  logic                  use_imm_q;
  logic [3:0]            alu_ctrl_q;
  logic [TW-1:0]         timer_q;
  logic                  nop_done_q;
  logic [CNT_WIDTH-1:0]  retired_q;
  logic                  accept;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and control decode; outputs follow the registered state
  always_comb begin
    state_d         = state_q;
    cmd_ready_o     = 1'b0;
    accept          = 1'b0;
    rs1_o           = '0;
    rs2_o           = '0;
    rd_o            = '0;
    imm_op_o        = '0;
    alu_src_o       = 1'b0;
    alu_ctrl_o      = '0;
    reg_write_o     = 1'b0;
    reg_write_src_o = 1'b0;
    mem_req_o       = 1'b0;
    mem_addr_o      = '0;
    done_o          = nop_done_q;
    branch_taken_o  = 1'b0;
    err_o           = 1'b0;
    busy_o          = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = ~rst_i;
        accept      = cmd_valid_i & ~rst_i;
        if (accept && (op_t'(cmd_op_i) != OP_NOP)) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rs1_o      = rs1_q;
        rs2_o      = rs2_q;
        rd_o       = rd_q;
        imm_op_o   = imm_q;
        alu_src_o  = use_imm_q;
        alu_ctrl_o = alu_ctrl_q;
        if (op_q == OP_LOAD) begin
          state_d = ST_MEM;
        end else begin
          done_o         = 1'b1;
          reg_write_o    = (op_q == OP_ALU) && (rd_q != '0);
          branch_taken_o = (op_q == OP_BRANCH) && eq_i;
          state_d        = ST_IDLE;
        end
      end
      ST_MEM: begin
        rs1_o      = rs1_q;
        rs2_o      = rs2_q;
        rd_o       = rd_q;
        imm_op_o   = imm_q;
        alu_src_o  = use_imm_q;
        alu_ctrl_o = alu_ctrl_q;
        mem_req_o  = 1'b1;
        mem_addr_o = mem_addr_q;
        if (mem_ack_i) begin
          reg_write_o     = (rd_q != '0);
          reg_write_src_o = 1'b1;
          done_o          = 1'b1;
          state_d         = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          err_o   = 1'b1;
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, load address, timeout timer and retired counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q       <= OP_ALU;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      alu_ctrl_q <= '0;
      mem_addr_q <= '0;
      timer_q    <= '0;
      nop_done_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      nop_done_q <= accept && (op_t'(cmd_op_i) == OP_NOP);
      if (accept) begin
        op_q       <= op_t'(cmd_op_i);
        rs1_q      <= cmd_rs1_i;
        rs2_q      <= cmd_rs2_i;
        rd_q       <= cmd_rd_i;
        imm_q      <= cmd_imm_i;
        use_imm_q  <= cmd_use_imm_i;
        alu_ctrl_q <= cmd_alu_ctrl_i;
      end
      if ((state_q == ST_EXEC) && (op_q == OP_LOAD)) begin
        mem_addr_q <= alu_out_i;
        timer_q    <= '0;
      end else if ((state_q == ST_MEM) && !mem_ack_i) begin
        timer_q <= timer_q + TW'(1);
      end
      if (done_o && !err_o) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  assign retired_o = retired_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: expected completions are queued at issue
// and matched against every done_o pulse; a 4-bit counter copy exercises wrap.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic [31:0] cmd_imm;
  logic        cmd_use_imm;
  logic [3:0]  cmd_alu_ctrl;
  logic        eq;
  logic [31:0] alu_out;
  logic        mem_ack;

  logic        cmd_ready, reg_write, reg_write_src, alu_src, mem_req;
  logic        done, branch_taken, err, busy;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_op, mem_addr, retired;
  logic [3:0]  alu_ctrl;

  logic        w_cmd_ready, w_reg_write, w_reg_write_src, w_alu_src, w_mem_req;
  logic        w_done, w_branch_taken, w_err, w_busy;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm_op, w_mem_addr;
  logic [3:0]  w_alu_ctrl, w_retired;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2), .cmd_rd_i(cmd_rd),
    .cmd_imm_i(cmd_imm), .cmd_use_imm_i(cmd_use_imm), .cmd_alu_ctrl_i(cmd_alu_ctrl),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .reg_write_o(reg_write),
    .reg_write_src_o(reg_write_src), .imm_op_o(imm_op), .alu_src_o(alu_src),
    .alu_ctrl_o(alu_ctrl), .eq_i(eq), .alu_out_i(alu_out), .mem_req_o(mem_req),
    .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .done_o(done),
    .branch_taken_o(branch_taken), .err_o(err), .busy_o(busy), .retired_o(retired)
  );

  alu_seq_ctrl #(.CNT_WIDTH(4)) dut_w (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(w_cmd_ready),
    .cmd_op_i(cmd_op), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2), .cmd_rd_i(cmd_rd),
    .cmd_imm_i(cmd_imm), .cmd_use_imm_i(cmd_use_imm), .cmd_alu_ctrl_i(cmd_alu_ctrl),
    .rs1_o(w_rs1), .rs2_o(w_rs2), .rd_o(w_rd), .reg_write_o(w_reg_write),
    .reg_write_src_o(w_reg_write_src), .imm_op_o(w_imm_op), .alu_src_o(w_alu_src),
    .alu_ctrl_o(w_alu_ctrl), .eq_i(eq), .alu_out_i(alu_out), .mem_req_o(w_mem_req),
    .mem_addr_o(w_mem_addr), .mem_ack_i(mem_ack), .done_o(w_done),
    .branch_taken_o(w_branch_taken), .err_o(w_err), .busy_o(w_busy), .retired_o(w_retired)
  );

  typedef struct {
    logic       we;
    logic       src;
    logic       br;
    logic       err;
    logic [4:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ret  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command and queue the completion it should produce
  task automatic issue(input op_t op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input logic [31:0] im, input logic ui,
                       input logic [3:0] ac, input logic to_exp);
    exp_t e;
    e.we  = ((op == OP_ALU) || ((op == OP_LOAD) && !to_exp)) && (d != 5'd0);
    e.src = (op == OP_LOAD) && !to_exp;
    e.br  = (op == OP_BRANCH) && eq;
    e.err = (op == OP_LOAD) && to_exp;
    e.rd  = d;
    @(posedge clk); #1;
    cmd_op = op; cmd_rs1 = r1; cmd_rs2 = r2; cmd_rd = d;
    cmd_imm = im; cmd_use_imm = ui; cmd_alu_ctrl = ac; cmd_valid = 1'b1;
    @(negedge clk);
    check("ready_before_accept", cmd_ready, 1);
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Completion monitor: every done_o pulse must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_ret = '0;
    end else begin
      check("write_without_done", reg_write & ~done, 0);
      check("narrow_done_match", w_done, done);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("reg_write", reg_write, e.we);
          check("reg_write_src", reg_write_src, e.src);
          check("branch_taken", branch_taken, e.br);
          check("err", err, e.err);
          if (e.we) check("rd", rd, e.rd);
          check("retired", retired, exp_ret);
          check("retired_narrow", w_retired, exp_ret[3:0]);
          if (!e.err) exp_ret = exp_ret + 32'd1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          cnt;
    logic [31:0] ret_before;
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = OP_ALU; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2;
    cmd_rd = 5'd3; cmd_imm = '0; cmd_use_imm = 1'b0; cmd_alu_ctrl = ALU_ADD;
    eq = 1'b0; alu_out = '0; mem_ack = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_rs1", rs1, 0);
    check("rst_retired", retired, 0);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_retired", retired, 0);

    // ALU with register operands, then with rd=0
    issue(OP_ALU, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, ALU_ADD, 1'b0);
    @(negedge clk);
    check("exec_rs1", rs1, 1);
    check("exec_rs2", rs2, 2);
    check("exec_alu_ctrl", alu_ctrl, ALU_ADD);
    check("exec_alu_src", alu_src, 0);
    check("exec_busy", busy, 1);
    check("exec_ready", cmd_ready, 0);
    wait_idle();
    check("retired_after_alu", retired, 1);
    issue(OP_ALU, 5'd4, 5'd5, 5'd0, 32'h0, 1'b0, ALU_XOR, 1'b0);
    wait_idle();

    // Branches: taken then not taken
    eq = 1'b1;
    issue(OP_BRANCH, 5'd1, 5'd1, 5'd9, 32'h0, 1'b0, ALU_SUB, 1'b0);
    wait_idle();
    eq = 1'b0;
    issue(OP_BRANCH, 5'd1, 5'd2, 5'd9, 32'h0, 1'b0, ALU_SUB, 1'b0);
    wait_idle();

    // Load acknowledged in the third memory cycle; address must hold
    alu_out = 32'h40;
    issue(OP_LOAD, 5'd0, 5'd0, 5'd5, 32'h40, 1'b1, ALU_ADD, 1'b0);
    @(negedge clk);
    check("load_imm", imm_op, 32'h40);
    check("load_alu_src", alu_src, 1);
    check("load_exec_req", mem_req, 0);
    @(posedge clk); #1 alu_out = 32'h99;
    @(negedge clk);
    check("load_req_c1", mem_req, 1);
    check("load_addr_c1", mem_addr, 32'h40);
    @(posedge clk); #1;
    @(negedge clk);
    check("load_req_c2", mem_req, 1);
    check("load_addr_c2", mem_addr, 32'h40);
    @(posedge clk); #1 mem_ack = 1'b1;
    @(negedge clk);
    check("load_req_c3", mem_req, 1);
    check("load_done_c3", done, 1);
    @(posedge clk); #1 mem_ack = 1'b0;
    wait_idle();

    // Load with no acknowledge times out after exactly MEM_TIMEOUT requests
    ret_before = exp_ret;
    issue(OP_LOAD, 5'd0, 5'd0, 5'd6, 32'h80, 1'b1, ALU_ADD, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      if (done) break;
    end
    check("timeout_req_cycles", 64'(cnt), 16);
    wait_idle();
    @(negedge clk);
    check("retired_after_timeout", retired, ret_before);

    // Reset during the second memory cycle aborts immediately
    issue(OP_LOAD, 5'd0, 5'd0, 5'd7, 32'h10, 1'b1, ALU_ADD, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_done", done, 0);
    check("abort_reg_write", reg_write, 0);
    check("abort_busy", busy, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    // Stray acknowledge outside a load has no effect
    mem_ack = 1'b1;
    issue(OP_ALU, 5'd3, 5'd4, 5'd8, 32'h0, 1'b0, ALU_AND, 1'b0);
    wait_idle();
    mem_ack = 1'b0;
    check("retired_after_abort", retired, 1);

    // Sixteen NOPs wrap the narrow counter 15 -> 0
    for (int i = 0; i < 16; i++) issue(OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, ALU_ADD, 1'b0);
    repeat (2) @(negedge clk);
    check("retired_final", retired, 17);
    check("retired_wrap", w_retired, 1);
    check("scoreboard_empty", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
